// File: rtl/tx_frame_arbiter.sv
// rtl/tx_frame_arbiter.sv - two-port round-robin frame arbiter onto a shared byte stream
//
// Purpose: grants one of two requesters at a time and forwards its frame
// bytes to the shared output with one cycle of latency. A grant ends after
// one of these events, and each is followed by an inter-frame gap:
//   - the granted port's rx_dv falls (end of frame),
//   - the granted port withdraws its request before starting,
//   - the start timeout expires,
//   - a frame overruns MAX_LEN, after which the rest of it is drained.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req0/req1             per-port send request
//   rxd0/rxd1, rx_dv0/1   per-port byte data and byte valid
//   gnt0/gnt1             registered one-hot grant
//   txd, tx_en            shared output byte and valid (txd is 0 when tx_en is low)
//   busy                  high whenever the FSM is not in IDLE
//   timeout_err, len_err  one-cycle error pulses
module tx_frame_arbiter #(
    parameter int IFG_CYCLES    = 4,
    parameter int START_TIMEOUT = 16,
    parameter int MAX_LEN       = 1518
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] rxd0,
    input  logic [7:0] rxd1,
    input  logic       rx_dv0,
    input  logic       rx_dv1,
    output logic       gnt0,
    output logic       gnt1,
    output logic [7:0] txd,
    output logic       tx_en,
    output logic       busy,
    output logic       timeout_err,
    output logic       len_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_XFER,
        S_DRAIN,
        S_IFG
    } state_e;

    localparam logic [7:0]  WAIT_LAST = 8'(START_TIMEOUT - 1);
    localparam logic [7:0]  IFG_LAST  = 8'(IFG_CYCLES - 1);
    localparam logic [15:0] LEN_MAX   = 16'(MAX_LEN);

    state_e      state_q;
    logic        sel_q;      // port currently holding the grant
    logic        last_q;     // port most recently granted
    logic [7:0]  wait_q;
    logic [7:0]  ifg_q;
    logic [15:0] len_q;
    logic [1:0]  gnt_q;
    logic [7:0]  txd_q;
    logic        tx_en_q;
    logic        busy_q;
    logic        tout_q;
    logic        lerr_q;

    logic        cur_req;
    logic        cur_dv;
    logic [7:0]  cur_rxd;
    logic        win_d;

    // Only the granted port's signals are ever looked at, so the other port
    // cannot disturb the output or the state machine.
    always_comb begin
        cur_req = sel_q ? req1   : req0;
        cur_dv  = sel_q ? rx_dv1 : rx_dv0;
        cur_rxd = sel_q ? rxd1   : rxd0;
        // On a tie the port that was not served last wins.
        win_d   = (req0 && req1) ? ~last_q : req1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
            wait_q  <= '0;
            ifg_q   <= '0;
            len_q   <= '0;
            gnt_q   <= '0;
            txd_q   <= '0;
            tx_en_q <= 1'b0;
            busy_q  <= 1'b0;
            tout_q  <= 1'b0;
            lerr_q  <= 1'b0;
        end else begin
            // Data valid and error flags are single-cycle unless re-asserted below.
            txd_q   <= '0;
            tx_en_q <= 1'b0;
            tout_q  <= 1'b0;
            lerr_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req0 || req1) begin
                        state_q <= S_GRANT;
                        sel_q   <= win_d;
                        last_q  <= win_d;
                        gnt_q   <= {win_d, ~win_d};
                        wait_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_GRANT: begin
                    if (cur_dv) begin
                        state_q <= S_XFER;
                        txd_q   <= cur_rxd;
                        tx_en_q <= 1'b1;
                        len_q   <= 16'd1;
                    end else if (!cur_req) begin
                        state_q <= S_IFG;
                        gnt_q   <= '0;
                        ifg_q   <= '0;
                    end else if (wait_q == WAIT_LAST) begin
                        state_q <= S_IFG;
                        gnt_q   <= '0;
                        ifg_q   <= '0;
                        tout_q  <= 1'b1;
                    end else begin
                        wait_q  <= wait_q + 8'd1;
                    end
                end
                S_XFER: begin
                    if (!cur_dv) begin
                        state_q <= S_IFG;
                        gnt_q   <= '0;
                        ifg_q   <= '0;
                    end else if (len_q == LEN_MAX) begin
                        // Byte MAX_LEN+1 is dropped; the remainder is swallowed in DRAIN.
                        state_q <= S_DRAIN;
                        lerr_q  <= 1'b1;
                    end else begin
                        txd_q   <= cur_rxd;
                        tx_en_q <= 1'b1;
                        len_q   <= len_q + 16'd1;
                    end
                end
                S_DRAIN: begin
                    if (!cur_dv) begin
                        state_q <= S_IFG;
                        gnt_q   <= '0;
                        ifg_q   <= '0;
                    end
                end
                S_IFG: begin
                    if (ifg_q == IFG_LAST) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        ifg_q   <= ifg_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt0        = gnt_q[0];
    assign gnt1        = gnt_q[1];
    assign txd         = txd_q;
    assign tx_en       = tx_en_q;
    assign busy        = busy_q;
    assign timeout_err = tout_q;
    assign len_err     = lerr_q;

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// tb/tb_tx_frame_arbiter.sv - directed self-checking bench for tx_frame_arbiter
module tb_tx_frame_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1;
    logic [7:0] rxd0, rxd1;
    logic       rx_dv0, rx_dv1;
    logic       gnt0, gnt1;
    logic [7:0] txd;
    logic       tx_en, busy, timeout_err, len_err;

    int checks   = 0;
    int failures = 0;

    tx_frame_arbiter #(
        .IFG_CYCLES   (4),
        .START_TIMEOUT(16),
        .MAX_LEN      (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0       (req0),
        .req1       (req1),
        .rxd0       (rxd0),
        .rxd1       (rxd1),
        .rx_dv0     (rx_dv0),
        .rx_dv1     (rx_dv1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .txd        (txd),
        .tx_en      (tx_en),
        .busy       (busy),
        .timeout_err(timeout_err),
        .len_err    (len_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 50) begin
            step();
            n++;
        end
        chk1("wait_idle_busy", busy, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
        rxd0 = 8'h00; rxd1 = 8'h00; rx_dv0 = 1'b0; rx_dv1 = 1'b0;
        step(); step();
        chk1("rst_gnt0", gnt0, 1'b0);
        chk1("rst_gnt1", gnt1, 1'b0);
        chk1("rst_tx_en", tx_en, 1'b0);
        chk8("rst_txd", txd, 8'h00);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_tout", timeout_err, 1'b0);
        chk1("rst_lerr", len_err, 1'b0);
        rst_n = 1'b1;
        step();
        chk1("idle_busy", busy, 1'b0);

        // Single frame A1 A2 A3 on port 0
        req0 = 1'b1;
        step();
        chk1("sf_gnt0", gnt0, 1'b1);
        chk1("sf_gnt1", gnt1, 1'b0);
        chk1("sf_busy", busy, 1'b1);
        chk1("sf_tx_en_grant", tx_en, 1'b0);
        rx_dv0 = 1'b1; rxd0 = 8'hA1;
        step();
        chk1("sf_tx_en1", tx_en, 1'b1);
        chk8("sf_txd1", txd, 8'hA1);
        rxd0 = 8'hA2;
        step();
        chk8("sf_txd2", txd, 8'hA2);
        rxd0 = 8'hA3;
        step();
        chk8("sf_txd3", txd, 8'hA3);
        chk1("sf_tx_en3", tx_en, 1'b1);
        rx_dv0 = 1'b0; rxd0 = 8'h00; req0 = 1'b0;
        step();
        chk1("sf_end_tx_en", tx_en, 1'b0);
        chk8("sf_end_txd", txd, 8'h00);
        chk1("sf_end_gnt0", gnt0, 1'b0);
        chk1("sf_end_busy", busy, 1'b1);
        req0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk1("ifg_gnt0", gnt0, 1'b0);
            chk1("ifg_busy", busy, 1'b1);
        end
        step();
        chk1("ifg_done_busy", busy, 1'b0);
        chk1("ifg_done_gnt0", gnt0, 1'b0);
        step();
        chk1("regrant_gnt0", gnt0, 1'b1);

        // Request withdrawn before start: no error
        req0 = 1'b0;
        step();
        chk1("wd_gnt0", gnt0, 1'b0);
        chk1("wd_tout", timeout_err, 1'b0);
        chk1("wd_busy", busy, 1'b1);
        wait_idle();

        // Tie from reset: port0, port1, port0
        rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        chk1("tie1_gnt0", gnt0, 1'b1);
        chk1("tie1_gnt1", gnt1, 1'b0);
        rx_dv0 = 1'b1; rxd0 = 8'h11;
        step();
        chk8("tie1_txd", txd, 8'h11);
        rx_dv0 = 1'b0;
        step();
        chk1("tie1_end_gnt0", gnt0, 1'b0);
        wait_idle();
        step();
        chk1("tie2_gnt1", gnt1, 1'b1);
        chk1("tie2_gnt0", gnt0, 1'b0);
        rx_dv1 = 1'b1; rxd1 = 8'h22;
        step();
        chk8("tie2_txd", txd, 8'h22);
        chk1("tie2_tx_en", tx_en, 1'b1);
        rx_dv1 = 1'b0;
        step();
        wait_idle();
        step();
        chk1("tie3_gnt0", gnt0, 1'b1);
        chk1("tie3_gnt1", gnt1, 1'b0);

        // Isolation: port1 activity while port0 holds the grant
        rx_dv1 = 1'b1; rxd1 = 8'hFF;
        step();
        chk1("iso_grant_tx_en", tx_en, 1'b0);
        chk1("iso_grant_gnt1", gnt1, 1'b0);
        chk1("iso_grant_busy", busy, 1'b1);
        for (int i = 0; i < 3; i++) begin
            rx_dv0 = 1'b1; rxd0 = 8'h31 + 8'(i); rx_dv1 = ~rx_dv1;
            step();
            chk8("iso_txd", txd, 8'h31 + 8'(i));
            chk1("iso_gnt1", gnt1, 1'b0);
        end
        rx_dv0 = 1'b0; rx_dv1 = 1'b1; req0 = 1'b0; req1 = 1'b0;
        step();
        chk1("iso_end_tx_en", tx_en, 1'b0);
        chk8("iso_end_txd", txd, 8'h00);
        rx_dv1 = 1'b0;
        wait_idle();

        // Start timeout on port1
        req1 = 1'b1;
        step();
        chk1("to_gnt1_first", gnt1, 1'b1);
        for (int i = 0; i < 15; i++) begin
            step();
            chk1("to_gnt1_hold", gnt1, 1'b1);
            chk1("to_no_pulse", timeout_err, 1'b0);
        end
        step();
        chk1("to_gnt1_drop", gnt1, 1'b0);
        chk1("to_pulse", timeout_err, 1'b1);
        chk1("to_busy0", busy, 1'b1);
        req1 = 1'b0;
        step();
        chk1("to_pulse_end", timeout_err, 1'b0);
        chk1("to_busy1", busy, 1'b1);
        step();
        chk1("to_busy2", busy, 1'b1);
        step();
        chk1("to_busy3", busy, 1'b1);
        step();
        chk1("to_busy_done", busy, 1'b0);

        // Truncation: 6-byte frame with MAX_LEN=4
        req0 = 1'b1;
        step();
        chk1("tr_gnt0", gnt0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            rx_dv0 = 1'b1; rxd0 = 8'hB1 + 8'(i);
            step();
            if (i < 4) begin
                chk1("tr_tx_en", tx_en, 1'b1);
                chk8("tr_txd", txd, 8'hB1 + 8'(i));
                chk1("tr_lerr_low", len_err, 1'b0);
            end else if (i == 4) begin
                chk1("tr_cut_tx_en", tx_en, 1'b0);
                chk8("tr_cut_txd", txd, 8'h00);
                chk1("tr_cut_lerr", len_err, 1'b1);
                chk1("tr_cut_gnt0", gnt0, 1'b1);
            end else begin
                chk1("tr_drain_lerr", len_err, 1'b0);
                chk1("tr_drain_tx_en", tx_en, 1'b0);
                chk1("tr_drain_gnt0", gnt0, 1'b1);
            end
        end
        rx_dv0 = 1'b0; req0 = 1'b0;
        step();
        chk1("tr_end_gnt0", gnt0, 1'b0);
        chk1("tr_end_busy", busy, 1'b1);
        chk1("tr_end_tx_en", tx_en, 1'b0);
        wait_idle();

        // Reset in the middle of a transfer
        req0 = 1'b1;
        step();
        chk1("rx_gnt0", gnt0, 1'b1);
        rx_dv0 = 1'b1; rxd0 = 8'hC1;
        step();
        chk8("rx_txd1", txd, 8'hC1);
        rxd0 = 8'hC2;
        #2;
        rst_n = 1'b0;
        #1;
        chk1("rx_async_tx_en", tx_en, 1'b0);
        chk1("rx_async_gnt0", gnt0, 1'b0);
        chk1("rx_async_busy", busy, 1'b0);
        chk8("rx_async_txd", txd, 8'h00);
        step();
        chk1("rx_no_tout", timeout_err, 1'b0);
        chk1("rx_no_lerr", len_err, 1'b0);
        rx_dv0 = 1'b0;
        rst_n = 1'b1;
        step();
        chk1("rx_regrant_gnt0", gnt0, 1'b1);
        chk1("rx_regrant_busy", busy, 1'b1);
        req0 = 1'b0;
        step();
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
